// File: rtl/bmp_pkg.sv
// bmp_pkg: shared definitions for the BMP loader slice.
//   - bmp_state_t : loader FSM states
//   - F_*         : byte offsets of the BMP header fields
//   - BMP_SIG     : "BM" signature as a little-endian 16-bit word
//   - in_field / put_byte : helpers for capturing little-endian 32-bit fields
package bmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SKIP,
    PIXEL,
    DONE,
    ERROR
  } bmp_state_t;

  localparam int unsigned F_OFFSET = 10;
  localparam int unsigned F_WIDTH  = 18;
  localparam int unsigned F_HEIGHT = 22;
  localparam int unsigned F_BPP    = 28;
  localparam int unsigned F_BPP_HI = 29;
  localparam int unsigned HDR_LEN  = 30;

  localparam logic [15:0] BMP_SIG = 16'h4D42;

  // True when byte address a falls inside the 4-byte field starting at base.
  function automatic logic in_field(input logic [24:0] a, input int unsigned base);
    return (a >= 25'(base)) && (a < 25'(base + 4));
  endfunction

  // Replace byte lane 'lane' of a little-endian word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[8*lane +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/bmp_wr_fifo.sv
// bmp_wr_fifo: 2-entry FIFO for pending pixel writes.
//   clk_sys : clock
//   rst_n   : synchronous active-low reset
//   flush   : synchronous clear (wins over push/pop)
//   push/din: write request and data; ignored when full unless popping too
//   pop     : read request; ignored when empty
//   dout    : head entry, forced to zero while empty
//   full/empty : occupancy flags
module bmp_wr_fifo
  import bmp_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wp, rp;
  logic [1:0]    cnt;
  logic          do_push, do_pop;

  always_comb begin
    full    = (cnt == 2'd2);
    empty   = (cnt == 2'd0);
    do_pop  = pop & ~empty;
    // When full, a push is only taken if the head leaves in the same cycle;
    // the new word then lands in the slot being vacated.
    do_push = push & (~full | do_pop);
    dout    = empty ? '0 : mem[rp];
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n || flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= ~wp;
      if (do_pop)  rp <= ~rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/bmp_loader.sv
// bmp_loader: parses a BMP byte stream from data_io and emits one 32-bit
// pixel write per pixel. Word address = (row << STRIDE_LOG2) + col, row 0 is
// the bottom row as stored in the file.
//   clk_sys, init_n           : clock, synchronous active-low reset
//   ioctl_download/wr/addr/dout : data_io download byte stream
//   wr_valid/wr_ready/wr_addr/wr_data : pixel write handshake, data {00,R,G,B}
//   loaded : image complete; error : header rejected or write overflow
//   img_w/img_h : header dimensions once accepted
module bmp_loader
  import bmp_pkg::*;
#(
  parameter int unsigned STRIDE_LOG2 = 9,
  parameter int unsigned MAX_W       = 512,
  parameter int unsigned MAX_H       = 312,
  parameter int unsigned ADDR_W      = 22
) (
  input  logic              clk_sys,
  input  logic              init_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              loaded,
  output logic              error,
  output logic [15:0]       img_w,
  output logic [15:0]       img_h
);

  bmp_state_t state;

  logic        wr_last, dl_last;
  logic        strobe, dl_rise, dl_fall;
  logic [15:0] sig;
  logic [31:0] hdr_off, hdr_w, hdr_h;
  logic [7:0]  bpp_lo;
  logic [15:0] bpp_full;
  logic        hdr_ok;
  logic        is32;
  logic [1:0]  byte_cnt, pad_left, pad;
  logic [15:0] col, row;
  logic [7:0]  pix_b, pix_g, pix_r;
  logic        pix_last, push, pop, overflow;
  logic        fifo_full, fifo_empty;
  logic [ADDR_W+31:0] push_word, head_word;

  always_comb begin
    strobe   = ioctl_wr & ~wr_last;
    dl_rise  = ioctl_download & ~dl_last;
    dl_fall  = ~ioctl_download & dl_last;
    bpp_full = {ioctl_dout, bpp_lo};
    // The bpp high byte is the current byte, so the check uses it live.
    hdr_ok   = (sig == BMP_SIG) &&
               (bpp_full == 16'd24 || bpp_full == 16'd32) &&
               (hdr_w != 32'd0) && (hdr_w <= 32'(MAX_W)) && (hdr_w[31:16] == 16'd0) &&
               (hdr_h[15:0] != 16'd0) && (hdr_h[31:16] == 16'd0) &&
               (hdr_off >= 32'(HDR_LEN)) && (hdr_off[31:24] == 8'd0);
    // (-3*w) mod 4 reduces to w mod 4.
    pad      = is32 ? 2'd0 : img_w[1:0];
    pix_last = (byte_cnt == (is32 ? 2'd3 : 2'd2));
    push     = (state == PIXEL) & strobe & ~dl_rise & (row < img_h) &
               (pad_left == 2'd0) & pix_last & (32'(row) < MAX_H);
    // For 24bpp the red byte is the current byte; for 32bpp it was stored.
    push_word = {ADDR_W'({row, col[STRIDE_LOG2-1:0]}), 8'h00,
                 (is32 ? pix_r : ioctl_dout), pix_g, pix_b};
    wr_valid = ~fifo_empty;
    pop      = wr_valid & wr_ready;
    overflow = push & fifo_full & ~pop;
    wr_addr  = head_word[ADDR_W+31:32];
    wr_data  = head_word[31:0];
  end

  bmp_wr_fifo #(
    .DW(ADDR_W + 32)
  ) u_fifo (
    .clk_sys (clk_sys),
    .rst_n   (init_n),
    .flush   (dl_rise),
    .push    (push),
    .din     (push_word),
    .pop     (pop),
    .dout    (head_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys) begin
    if (!init_n) begin
      state    <= IDLE;
      wr_last  <= 1'b0;
      dl_last  <= 1'b0;
      loaded   <= 1'b0;
      error    <= 1'b0;
      img_w    <= '0;
      img_h    <= '0;
      sig      <= '0;
      hdr_off  <= '0;
      hdr_w    <= '0;
      hdr_h    <= '0;
      bpp_lo   <= '0;
      is32     <= 1'b0;
      byte_cnt <= '0;
      pad_left <= '0;
      col      <= '0;
      row      <= '0;
      pix_b    <= '0;
      pix_g    <= '0;
      pix_r    <= '0;
    end else begin
      wr_last <= ioctl_wr;
      dl_last <= ioctl_download;
      if (overflow) error <= 1'b1;

      if (dl_rise) begin
        state    <= HEADER;
        loaded   <= 1'b0;
        error    <= 1'b0;
        img_w    <= '0;
        img_h    <= '0;
        sig      <= '0;
        hdr_off  <= '0;
        hdr_w    <= '0;
        hdr_h    <= '0;
        bpp_lo   <= '0;
        is32     <= 1'b0;
        byte_cnt <= '0;
        pad_left <= '0;
        col      <= '0;
        row      <= '0;
      end else begin
        case (state)
          HEADER: begin
            if (dl_fall) begin
              state <= ERROR;
              error <= 1'b1;
            end else if (strobe) begin
              if (ioctl_addr == 25'd0) sig[7:0]  <= ioctl_dout;
              if (ioctl_addr == 25'd1) sig[15:8] <= ioctl_dout;
              if (in_field(ioctl_addr, F_OFFSET))
                hdr_off <= put_byte(hdr_off, 2'(ioctl_addr - 25'(F_OFFSET)), ioctl_dout);
              if (in_field(ioctl_addr, F_WIDTH))
                hdr_w <= put_byte(hdr_w, 2'(ioctl_addr - 25'(F_WIDTH)), ioctl_dout);
              if (in_field(ioctl_addr, F_HEIGHT))
                hdr_h <= put_byte(hdr_h, 2'(ioctl_addr - 25'(F_HEIGHT)), ioctl_dout);
              if (ioctl_addr == 25'(F_BPP)) bpp_lo <= ioctl_dout;
              if (ioctl_addr == 25'(F_BPP_HI)) begin
                if (hdr_ok) begin
                  img_w <= hdr_w[15:0];
                  img_h <= hdr_h[15:0];
                  is32  <= (bpp_full == 16'd32);
                  state <= (hdr_off == 32'(HDR_LEN)) ? PIXEL : SKIP;
                end else begin
                  state <= ERROR;
                  error <= 1'b1;
                end
              end
            end
          end
          SKIP: begin
            if (dl_fall) state <= DONE;
            else if (strobe && ioctl_addr == 25'(hdr_off - 32'd1)) state <= PIXEL;
          end
          PIXEL: begin
            if (dl_fall) begin
              state <= DONE;
            end else if (strobe && row < img_h) begin
              if (pad_left != 2'd0) begin
                pad_left <= pad_left - 2'd1;
                if (pad_left == 2'd1) begin
                  col <= '0;
                  row <= row + 16'd1;
                end
              end else begin
                case (byte_cnt)
                  2'd0:    pix_b <= ioctl_dout;
                  2'd1:    pix_g <= ioctl_dout;
                  2'd2:    pix_r <= ioctl_dout;
                  default: ;
                endcase
                if (pix_last) begin
                  byte_cnt <= '0;
                  if (col + 16'd1 == img_w) begin
                    if (pad == 2'd0) begin
                      col <= '0;
                      row <= row + 16'd1;
                    end else begin
                      col      <= col + 16'd1;
                      pad_left <= pad;
                    end
                  end else begin
                    col <= col + 16'd1;
                  end
                end else begin
                  byte_cnt <= byte_cnt + 2'd1;
                end
              end
            end
          end
          DONE: begin
            if (fifo_empty) loaded <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bmp_loader.sv
// tb_bmp_loader: directed bench for bmp_loader. A table of BMP headers is
// built into byte streams, played through the data_io port and the captured
// pixel writes are compared against a bench-side model; hand sequences cover
// back-pressure, restart and reset corner cases.
module tb_bmp_loader;

  localparam int unsigned ADDR_W = 22;

  logic              clk_sys = 1'b0;
  logic              init_n, ioctl_download, ioctl_wr, wr_ready;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              wr_valid, loaded, error;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [15:0]       img_w, img_h;

  always #5 clk_sys = ~clk_sys;

  bmp_loader #(
    .STRIDE_LOG2(9),
    .MAX_W(512),
    .MAX_H(312),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk_sys        (clk_sys),
    .init_n         (init_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .loaded         (loaded),
    .error          (error),
    .img_w          (img_w),
    .img_h          (img_h)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]        fb[$];
  logic [ADDR_W-1:0] cap_a[$];
  logic [31:0]       cap_d[$];

  // Inputs change 1 time unit after posedge, so at negedge the handshake
  // matches what the DUT sees on the following posedge.
  always @(negedge clk_sys) begin
    if (wr_valid && wr_ready) begin
      cap_a.push_back(wr_addr);
      cap_d.push_back(wr_data);
    end
  end

  typedef struct {
    logic [15:0] sig;
    int          w;
    int          h;
    int          bpp;
    int          off;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] pb(input int r, input int c, input int k);
    return 8'(r * 37 + c * 11 + k * 71 + 5);
  endfunction

  function automatic logic [53:0] exp_word(input int r, input int c);
    return {22'(r * 512 + c), 8'h00, pb(r, c, 2), pb(r, c, 1), pb(r, c, 0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic build_file(input logic [15:0] sig, input int w, input int h,
                            input int bpp, input int off);
    int hl, bytes_pp, pad;
    logic [31:0] ow, ww, hh;
    fb.delete();
    hl = (off > 30) ? off : 30;
    for (int i = 0; i < hl; i++) fb.push_back(8'h00);
    ow = 32'(off);
    ww = 32'(w);
    hh = 32'(h);
    fb[0] = sig[7:0];
    fb[1] = sig[15:8];
    for (int i = 0; i < 4; i++) begin
      fb[10 + i] = ow[8*i +: 8];
      fb[18 + i] = ww[8*i +: 8];
      fb[22 + i] = hh[8*i +: 8];
    end
    fb[28] = 8'(bpp);
    fb[29] = 8'(bpp >> 8);
    bytes_pp = bpp / 8;
    pad = (bpp == 24) ? (4 - (w * 3) % 4) % 4 : 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++)
        for (int k = 0; k < bytes_pp; k++)
          fb.push_back(k < 3 ? pb(r, c, k) : 8'hA5);
      for (int p = 0; p < pad; p++) fb.push_back(8'hEE);
    end
  endtask

  // Plays nbytes of fb (all if negative); wr_ready is raised together with
  // byte ready_idx when ready_idx >= 0.
  task automatic send_file(input int nbytes, input bit finish_dl, input int ready_idx);
    int n;
    n = (nbytes < 0 || nbytes > fb.size()) ? fb.size() : nbytes;
    @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys); #1;
      ioctl_addr = 25'(i);
      ioctl_dout = fb[i];
      ioctl_wr   = 1'b1;
      if (i == ready_idx) wr_ready = 1'b1;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
    end
    if (finish_dl) begin
      @(posedge clk_sys); #1;
      ioctl_download = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (!(loaded || error) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    tests++;
    if (!(loaded || error)) begin
      fails++;
      $display("FAIL %s_timeout: loaded=%0b error=%0b, required one of them high", name, loaded, error);
    end
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic check_writes(input string name, input int w, input int rows);
    check({name, "_count"}, 64'(cap_a.size()), 64'(rows * w));
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        int i;
        i = r * w + c;
        if (i < cap_a.size())
          check($sformatf("%s_w%0d", name, i), {cap_a[i], cap_d[i]}, exp_word(r, c));
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    init_n         = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    wr_ready       = 1'b1;

    vecs[0] = '{16'h4D42,   4,   2, 24, 54, 1'b0};
    vecs[1] = '{16'h4D42,   3,   2, 24, 54, 1'b0};
    vecs[2] = '{16'h4D42,   4,   2, 16, 54, 1'b1};
    vecs[3] = '{16'h5958,   4,   2, 24, 54, 1'b1};
    vecs[4] = '{16'h4D42,   2,   2, 32, 30, 1'b0};
    vecs[5] = '{16'h4D42, 513,   1, 24, 54, 1'b1};
    vecs[6] = '{16'h4D42,   4,   1, 24, 29, 1'b1};
    vecs[7] = '{16'h4D42,   1, 400, 24, 54, 1'b0};
    vecs[8] = '{16'h4D42,   2,   1, 24, 60, 1'b0};
    vecs[9] = '{16'h4D42,   4,   0, 24, 54, 1'b1};

    repeat (3) @(posedge clk_sys);
    #1 init_n = 1'b1;
    @(negedge clk_sys);
    check("rst_wr_valid", 64'(wr_valid), 64'd0);
    check("rst_wr_addr",  64'(wr_addr),  64'd0);
    check("rst_wr_data",  64'(wr_data),  64'd0);
    check("rst_loaded",   64'(loaded),   64'd0);
    check("rst_error",    64'(error),    64'd0);
    check("rst_img_w",    64'(img_w),    64'd0);
    check("rst_img_h",    64'(img_h),    64'd0);

    for (int v = 0; v < 10; v++) begin
      string nm;
      int rows;
      nm = $sformatf("v%0d", v);
      build_file(vecs[v].sig, vecs[v].w, vecs[v].h, vecs[v].bpp, vecs[v].off);
      cap_a.delete();
      cap_d.delete();
      send_file(-1, 1'b1, -1);
      wait_done(nm);
      check({nm, "_error"},  64'(error),  64'(vecs[v].exp_err));
      check({nm, "_loaded"}, 64'(loaded), 64'(!vecs[v].exp_err));
      rows = vecs[v].exp_err ? 0 : (vecs[v].h < 312 ? vecs[v].h : 312);
      check_writes(nm, vecs[v].w, rows);
      if (!vecs[v].exp_err) begin
        check({nm, "_img_w"}, 64'(img_w), 64'(vecs[v].w));
        check({nm, "_img_h"}, 64'(img_h), 64'(vecs[v].h));
      end
      if (v == 7 && cap_a.size() > 0)
        check("tall_last_addr", 64'(cap_a[cap_a.size() - 1]), 64'(311 * 512));
    end

    // Back-pressure: two words buffered, third dropped.
    build_file(16'h4D42, 3, 1, 24, 54);
    cap_a.delete();
    cap_d.delete();
    @(posedge clk_sys); #1 wr_ready = 1'b0;
    send_file(-1, 1'b1, -1);
    repeat (3) @(negedge clk_sys);
    check("drop_error",   64'(error),    64'd1);
    check("drop_valid",   64'(wr_valid), 64'd1);
    check("drop_head",    {wr_addr, wr_data}, exp_word(0, 0));
    @(posedge clk_sys); #1 wr_ready = 1'b1;
    repeat (6) @(negedge clk_sys);
    check_writes("drop", 2, 1);

    // Push while full with a simultaneous pop: nothing lost.
    build_file(16'h4D42, 3, 1, 24, 54);
    cap_a.delete();
    cap_d.delete();
    @(posedge clk_sys); #1 wr_ready = 1'b0;
    send_file(-1, 1'b1, 62);
    wait_done("simul");
    check("simul_error",  64'(error),  64'd0);
    check("simul_loaded", 64'(loaded), 64'd1);
    check_writes("simul", 3, 1);

    // New download started with words pending mid-PIXEL.
    build_file(16'h4D42, 4, 2, 24, 54);
    @(posedge clk_sys); #1 wr_ready = 1'b0;
    send_file(64, 1'b0, -1);
    @(negedge clk_sys);
    check("restart_pre_valid", 64'(wr_valid), 64'd1);
    @(posedge clk_sys); #1 ioctl_download = 1'b0;
    @(posedge clk_sys); #1 ioctl_download = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("restart_valid",  64'(wr_valid), 64'd0);
    check("restart_addr",   64'(wr_addr),  64'd0);
    check("restart_loaded", 64'(loaded),   64'd0);
    check("restart_error",  64'(error),    64'd0);
    cap_a.delete();
    cap_d.delete();
    @(posedge clk_sys); #1 wr_ready = 1'b1;
    send_file(-1, 1'b1, -1);
    wait_done("restart");
    check("restart_loaded2", 64'(loaded), 64'd1);
    check_writes("restart", 4, 2);

    // init_n pulse mid-PIXEL.
    build_file(16'h4D42, 4, 2, 24, 54);
    @(posedge clk_sys); #1 wr_ready = 1'b0;
    send_file(61, 1'b0, -1);
    @(negedge clk_sys);
    check("rst2_pre_valid", 64'(wr_valid), 64'd1);
    @(posedge clk_sys); #1;
    init_n         = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1 init_n = 1'b1;
    @(negedge clk_sys);
    check("rst2_wr_valid", 64'(wr_valid), 64'd0);
    check("rst2_wr_addr",  64'(wr_addr),  64'd0);
    check("rst2_wr_data",  64'(wr_data),  64'd0);
    check("rst2_loaded",   64'(loaded),   64'd0);
    check("rst2_error",    64'(error),    64'd0);
    check("rst2_img_w",    64'(img_w),    64'd0);
    check("rst2_img_h",    64'(img_h),    64'd0);
    cap_a.delete();
    cap_d.delete();
    @(posedge clk_sys); #1 wr_ready = 1'b1;
    send_file(-1, 1'b1, -1);
    wait_done("rst2");
    check("rst2_loaded2", 64'(loaded), 64'd1);
    check("rst2_error2",  64'(error),  64'd0);
    check_writes("rst2", 4, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bmp_loader.md
# bmp_loader

Upstream stage of the menu's bitmap path. It consumes the raw BMP byte stream from `data_io` (`ioctl_*`, `clk_sys` domain), validates the BMP header, strips header and row padding, and emits one 32-bit pixel write per pixel toward the SDRAM upload port. The pixel word address uses the fixed row stride that the video fetch side reads back: word = (row << STRIDE_LOG2) + col, with row 0 being the bottom image row as stored in the file. It replaces the ad-hoc header-offset capture in the top level.

## Interface
- `STRIDE_LOG2`, 9: log2 of the row stride in 32-bit words.
- `MAX_W`, 512: widest image accepted; must be ≤ 2^STRIDE_LOG2.
- `MAX_H`, 312: rows written; rows ≥ MAX_H are consumed and discarded.
- `ADDR_W`, 22: word-address width of `wr_addr`.
- `clk_sys` in 1: single clock.
- `init_n` in 1: reset, synchronous, active-low.
- `ioctl_download` in 1: download active (level).
- `ioctl_wr` in 1: byte strobe; one byte is taken per rising edge.
- `ioctl_addr` in 25: byte offset in the file; sequential from 0.
- `ioctl_dout` in 8: byte data.
- `wr_valid` out 1: pixel word available.
- `wr_ready` in 1: consumer takes the word when `wr_valid & wr_ready`.
- `wr_addr` out ADDR_W: word address.
- `wr_data` out 32: {8'h00, R, G, B}.
- `loaded` out 1: image complete and valid; level.
- `error` out 1: header rejected or FIFO overflow; sticky until the next download starts.
- `img_w` out 16: header width, valid once the header is accepted.
- `img_h` out 16: header height, valid once the header is accepted.

## Operation
- Edge detection:
  - `ioctl_wr` and `ioctl_download` are registered once.
  - A byte strobe is `ioctl_wr & ~wr_last`.
  - Download start is the rise of `ioctl_download`; download end is its fall.
- States: IDLE, HEADER, SKIP, PIXEL, DONE, ERROR.
- Download start from any state:
  - go to HEADER;
  - clear `loaded`, `error`, all counters and the FIFO.
- HEADER: capture file bytes 0..29 by `ioctl_addr`.
  - signature = bytes 0..1
  - offset = bytes 10..13
  - width = bytes 18..21
  - height = bytes 22..25
  - bpp = bytes 28..29
- On the byte at addr 29, the header is accepted only if all of these hold:
  - sig == 16'h4D42;
  - bpp ∈ {24, 32};
  - 1 ≤ width ≤ MAX_W and width[31:16] == 0;
  - height ≠ 0 and height[31:16] == 0 (this rejects negative, top-down images);
  - 30 ≤ offset < 2^24.
- If accepted: go to PIXEL when offset == 30, else go to SKIP. If rejected: go to ERROR with `error` = 1.
- SKIP: discard bytes; go to PIXEL after the byte at addr offset−1.
- PIXEL: pixel bytes arrive in B, G, R (and A for 32bpp) order.
  - A byte counter 0..Bpp−1 assembles the word. Alpha is ignored.
  - When a pixel completes: col += 1.
  - When col reaches width: skip pad bytes, then col = 0 and row += 1.
  - pad = (−3·width) mod 4 for 24bpp; pad = 0 for 32bpp.
  - A pixel is pushed to the FIFO only if row < MAX_H.
  - After row == height, further bytes are ignored.
- Download end:
  - from PIXEL or SKIP → DONE with `loaded` = 1. A short file is still marked loaded.
  - from HEADER → ERROR.
- DONE and ERROR hold until the next download start.
- Output FIFO: 2 entries of {addr, data}.
  - A push when full with no simultaneous pop drops the word and sets `error`.
  - Push and pop in the same cycle while full is legal and loses nothing.
- Arithmetic: col is 16 bits and row is 16 bits. `wr_addr` = {row, col[STRIDE_LOG2−1:0]}, truncated to ADDR_W.

## Timing
- Reset values: `wr_valid` = 0, `wr_addr` = 0, `wr_data` = 0, `loaded` = 0, `error` = 0, `img_w` = 0, `img_h` = 0; state = IDLE.
- Latency: a byte strobe detected in cycle N that completes a pixel into an empty FIFO gives `wr_valid` = 1 in cycle N+1.
- `wr_valid`, `wr_addr` and `wr_data` stay stable until accepted.
- `loaded` rises 1 cycle after the registered fall of `ioctl_download`, and only if the FIFO is empty. Otherwise it rises the cycle after the FIFO drains.
- A download start while words are pending discards them; `wr_valid` = 0 the next cycle.
- `init_n` low at any point resets everything on that clock edge, including mid-download.

## Structure
- Package `bmp_pkg`:
  - state enum;
  - BMP field offsets (10, 18, 22, 28, 29);
  - the signature constant 16'h4D42.
- One sub-module, `bmp_wr_fifo`: a 2-entry FIFO parameterised on data width, with full/empty and a same-cycle push/pop rule.

## Test plan
- Valid 24bpp BMP, 4×2, offset 54: 8 writes in order, addresses 0,1,2,3,512,513,514,515; first data {00,R,G,B} from bytes 54..56; `loaded` = 1 after download end.
- 24bpp, width 3, offset 54: 3 pad bytes are skipped per row; row 1 starts at file byte 66 and writes address 512.
- Rejected headers:
  - bpp = 16 → `error` = 1, `loaded` = 0, no writes;
  - bytes 0..1 = "XY" → same result.
- `wr_ready` held low for 3 pixels: the first 2 are buffered and the 3rd is dropped with `error` = 1. With `wr_ready` = 1 and a simultaneous push while full, no drop occurs.
- Height 400, width 1, MAX_H = 312: exactly 312 writes; the last address is 311·512.
- New download started mid-PIXEL, and `init_n` pulsed mid-PIXEL: the FIFO is flushed, outputs return to reset values, and the next file loads cleanly from address 0.
